// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: multiplexed N-digit 7-segment scan controller
// with a shared hex decoder, frame-aligned double buffering and LZ blanking.
module disp_scan_ctrl #(
  parameter int N_DIG = 8,
  parameter int DIV   = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [4*N_DIG-1:0] data,
  input  logic               blank_lz,
  output logic               ack,
  output logic [3:0]         dec_hex,
  input  logic [6:0]         dec_seg,
  output logic [6:0]         seg,
  output logic [N_DIG-1:0]   an
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  logic [PW-1:0]      presc_q, presc_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [4*N_DIG-1:0] shadow_q, shadow_d;
  logic [4*N_DIG-1:0] disp_q, disp_d;
  logic               pend_q, pend_d;
  logic               ack_q, ack_d;
  logic [6:0]         seg_q, seg_d;
  logic [N_DIG-1:0]   an_q, an_d;

  logic               wrap;
  logic               last;
  logic               frame;
  logic [3:0]         hex_cur;
  logic [N_DIG:0]     zero_from;
  logic               blank;
  logic [N_DIG-1:0]   an_sel;

  // Counters, buffers and handshake next state
  always_comb begin
    wrap     = (presc_q == PW'(DIV - 1));
    last     = (idx_q == IW'(N_DIG - 1));
    frame    = wrap & last;
    presc_d  = wrap ? '0 : presc_q + PW'(1);
    idx_d    = idx_q;
    if (wrap) begin
      idx_d = last ? '0 : idx_q + IW'(1);
    end
    shadow_d = load ? data : shadow_q;
    disp_d   = (frame && pend_q) ? shadow_q : disp_q;
    pend_d   = pend_q;
    if (frame) begin
      pend_d = 1'b0;
    end
    if (load) begin
      pend_d = 1'b1;
    end
    ack_d    = load;
  end

  // Current digit nibble, enable pattern and leading-zero blanking
  always_comb begin
    hex_cur = 4'h0;
    an_sel  = '1;
    blank   = 1'b0;
    zero_from = '0;
    zero_from[N_DIG] = 1'b1;
    for (int i = N_DIG - 1; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] & (disp_q[4*i +: 4] == 4'h0);
    end
    for (int i = 0; i < N_DIG; i++) begin
      if (idx_q == IW'(i)) begin
        hex_cur   = disp_q[4*i +: 4];
        an_sel[i] = 1'b0;
        blank     = blank_lz && (i != 0) && zero_from[i];
      end
    end
  end

  // Output register next state: guard slot first, then digit drive
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    if (presc_q != '0) begin
      an_d  = an_sel;
      seg_d = blank ? 7'h7F : dec_seg;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      pend_q   <= 1'b0;
      ack_q    <= 1'b0;
      seg_q    <= 7'h7F;
      an_q     <= '1;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign dec_hex = hex_cur;
  assign ack     = ack_q;
  assign seg     = seg_q;
  assign an      = an_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed checks of scan timing, frame-aligned
// update, collision, blanking, held load and async reset.
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic        blank_lz;
  logic        ack;
  logic [3:0]  dec_hex;
  logic [6:0]  dec_seg;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0111000;
  localparam logic [6:0] SB = 7'b1111111;

  disp_scan_ctrl #(.N_DIG(4), .DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data     (data),
    .blank_lz (blank_lz),
    .ack      (ack),
    .dec_hex  (dec_hex),
    .dec_seg  (dec_seg),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  // Board-side shared decoder, a..g MSB first, active-low
  always_comb begin
    case (dec_hex)
      4'h0: dec_seg = 7'b0000001;
      4'h1: dec_seg = 7'b1001111;
      4'h2: dec_seg = 7'b0010010;
      4'h3: dec_seg = 7'b0000110;
      4'h4: dec_seg = 7'b1001100;
      4'h5: dec_seg = 7'b0100100;
      4'h6: dec_seg = 7'b0100000;
      4'h7: dec_seg = 7'b0001111;
      4'h8: dec_seg = 7'b0000000;
      4'h9: dec_seg = 7'b0000100;
      4'hA: dec_seg = 7'b0001000;
      4'hB: dec_seg = 7'b1100000;
      4'hC: dec_seg = 7'b0110001;
      4'hD: dec_seg = 7'b1000010;
      4'hE: dec_seg = 7'b0110000;
      default: dec_seg = 7'b0111000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // One full frame: guard + 3 lit cycles per digit, digit 0 first
  task automatic chk_frame(input logic [15:0] hx,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] sx [4];
    logic [3:0] ae;
    sx[0] = s0; sx[1] = s1; sx[2] = s2; sx[3] = s3;
    for (int d = 0; d < 4; d++) begin
      tick();
      check("guard_an", an, 4'hF);
      check("guard_seg", seg, SB);
      check("dec_hex", dec_hex, hx[4*d +: 4]);
      ae = ~(4'b0001 << d);
      for (int k = 0; k < 3; k++) begin
        tick();
        check("dig_an", an, ae);
        check("dig_seg", seg, sx[d]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data = 16'h0; blank_lz = 1'b0;
    #12;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, SB);
    check("rst_ack", ack, 1'b0);
    check("rst_hex", dec_hex, 4'h0);

    // Load right at reset release
    @(posedge clk); #1;
    rst = 1'b0; load = 1'b1; data = 16'h12AF; cyc = 0;
    tick();
    check("ack1", ack, 1'b1);
    check("first_guard_an", an, 4'hF);
    check("first_guard_seg", seg, SB);
    load = 1'b0;
    tick();
    check("ack1_off", ack, 1'b0);
    check("pre_an", an, 4'hE);
    check("pre_seg", seg, S0);
    run_to(16);
    chk_frame(16'h12AF, SF, SA, S2, S1);

    // Frame-boundary collision
    run_to(33);
    load = 1'b1; data = 16'h1111;
    tick();
    check("ack_c1", ack, 1'b1);
    load = 1'b0;
    tick();
    check("ack_c1_off", ack, 1'b0);
    run_to(47);
    load = 1'b1; data = 16'h2222;
    tick();
    check("ack_c2", ack, 1'b1);
    load = 1'b0;
    chk_frame(16'h1111, S1, S1, S1, S1);
    chk_frame(16'h2222, S2, S2, S2, S2);

    // Leading-zero blanking
    load = 1'b1; data = 16'h0030; blank_lz = 1'b1;
    tick();
    load = 1'b0;
    run_to(96);
    chk_frame(16'h0030, S0, S3, SB, SB);
    blank_lz = 1'b0;
    chk_frame(16'h0030, S0, S3, S0, S0);
    load = 1'b1; data = 16'h0000;
    tick();
    load = 1'b0; blank_lz = 1'b1;
    run_to(144);
    chk_frame(16'h0000, S0, SB, SB, SB);

    // Held load, last writer wins
    blank_lz = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      load = 1'b1; data = 16'(i);
      tick();
      check("held_ack", ack, 1'b1);
    end
    load = 1'b0;
    tick();
    check("held_ack_off", ack, 1'b0);
    run_to(176);
    chk_frame(16'h0005, S5, S0, S0, S0);

    // Async reset mid-scan with a pending value
    run_to(193);
    load = 1'b1; data = 16'hFFFF;
    tick();
    load = 1'b0;
    check("pre_rst_ack", ack, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ack", ack, 1'b0);
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_seg", seg, SB);
    check("mid_rst_hex", dec_hex, 4'h0);
    @(posedge clk); #1;
    check("hold_rst_an", an, 4'hF);
    rst = 1'b0; cyc = 0;
    tick();
    check("rel_guard_an", an, 4'hF);
    check("rel_guard_seg", seg, SB);
    check("rel_ack", ack, 1'b0);
    tick();
    check("rel_an", an, 4'hE);
    check("rel_seg", seg, S0);
    run_to(16);
    chk_frame(16'h0000, S0, S0, S0, S0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
